axi_sram_responder: RTL and testbench
=====================================

# axi_sram_responder

AXI4 slave (responder) that serves the DLA controller's DMA master bursts from a word-organised single-port SRAM. It stands in for the off-chip memory at the far end of the controller's AXI master port, both in system simulation and in FPGA prototypes. The block accepts INCR bursts on the AW/W/B and AR/R channels and runs one transaction at a time. Each beat is translated into one SRAM access, with a 1-cycle read latency.

## Interface
Parameters:
- MEM_WORDS, 65536: SRAM depth in 32-bit words. Valid word addresses are 0..MEM_WORDS-1.
- AW_MEM, $clog2(MEM_WORDS): width of the SRAM word address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- awid_s_i / awaddr_s_i / awlen_s_i / awsize_s_i / awburst_s_i / awvalid_s_i  in  `ID_WIDTH/`ADDR_WIDTH/`LEN_WIDTH/`SIZE_WIDTH/`BURST_WIDTH/1  write address channel.
- awready_s_o  out  1  write address ready.
- wdata_s_i / wstrb_s_i / wlast_s_i / wvalid_s_i  in  `DATA_WIDTH/`DATA_WIDTH/8/1/1  write data channel.
- wready_s_o  out  1  write data ready.
- bid_s_o / bresp_s_o / bvalid_s_o  out  `ID_WIDTH/`BRESP_WIDTH/1  write response channel.
- bready_s_i  in  1  write response ready.
- arid_s_i / araddr_s_i / arlen_s_i / arsize_s_i / arburst_s_i / arvalid_s_i  in  read address channel, same widths as AW.
- arready_s_o  out  1  read address ready.
- rid_s_o / rdata_s_o / rlast_s_o / rvalid_s_o / rresp_s_o  out  `ID_WIDTH/`DATA_WIDTH/1/1/`RRESP_WIDTH  read data channel.
- rready_s_i  in  1  read ready.
- mem_cs_o  out  1  SRAM chip select, active-high.
- mem_addr_o  out  AW_MEM  SRAM word address.
- mem_wdata_o  out  32  SRAM write data.
- mem_web_o  out  4  SRAM per-byte write enable, active-low. 4'hF means no write.
- mem_rdata_i  in  32  SRAM read data, valid 1 cycle after a read with mem_cs_o=1 and mem_web_o=4'hF.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA.
- IDLE arbitration. awready_s_o = awvalid_s_i & (~arvalid_s_i | prio_wr). arready_s_o is the complement grant.
  - If both AW and AR are valid, the side selected by prio_wr wins. prio_wr toggles after every granted transaction.
  - Reset value of prio_wr is 1 (write first).
- Address capture. On an AW or AR handshake the block latches id, len, word address = addr[AW_MEM+1:2], and an error flag.
  - addr[1:0] is ignored.
  - err = (size != 2) | (burst != INCR) | (word address + len >= MEM_WORDS).
- WR_DATA:
  - wready_s_o = 1.
  - On each W handshake, if err=0: mem_cs_o=1, mem_web_o = ~wstrb_s_i, mem_wdata_o = wdata_s_i. The address then increments by 1.
  - If err=1 the beat is consumed and mem_web_o stays 4'hF.
  - The beat counter counts 0..len. wlast_s_i is expected only on beat len. Any mismatch sets err.
  - After beat len, go to WR_RESP.
- WR_RESP:
  - bvalid_s_o = 1, bid_s_o = latched id, bresp_s_o = err ? SLVERR : OKAY.
  - Hold until bready_s_i, then go to IDLE.
- RD_REQ:
  - mem_cs_o = 1, mem_web_o = 4'hF, mem_addr_o = current address.
  - Go to RD_DATA.
  - If err=1 the SRAM access is suppressed (mem_cs_o = 0).
- RD_DATA:
  - rvalid_s_o = 1, rdata_s_o = mem_rdata_i registered on entry (0 if err).
  - rresp_s_o = err ? SLVERR : OKAY, rlast_s_o = (beat == len), rid_s_o = latched id.
  - rdata is held stable until rready_s_i. On the handshake: if last, go to IDLE; otherwise increment address and beat, then go to RD_REQ.

## Timing
- Reset values:
  - All *valid/*ready outputs 0.
  - bresp/rresp/rdata/rid/bid 0.
  - mem_cs_o 0, mem_web_o 4'hF, mem_addr_o 0, mem_wdata_o 0.
  - State IDLE, prio_wr 1.
- Write burst: AW handshake at cycle t. First wready at t+1. One beat per cycle while wvalid holds. bvalid appears the cycle after the last beat.
- Read burst: AR handshake at t. RD_REQ at t+1. First rvalid at t+2. Each beat costs 2 cycles, so throughput is 1 beat per 2 cycles.
- AXI rules:
  - valid outputs never drop before their handshake.
  - Payload is stable while valid=1 and ready=0.
  - awready/arready are never both 1 in the same cycle.
- Simultaneous AW and AR in IDLE: exactly one is granted. The other waits in IDLE with its ready at 0.
- Reset asserted mid-burst: return to IDLE on the next edge. No further SRAM writes occur and any pending response is dropped.
- Address wrap: not possible. Bursts that would cross MEM_WORDS are flagged by err before any access.

## Structure
- The shared package holds:
  - the state enum `axi_rsp_state_e`;
  - the BURST_INCR constant;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the `ID_WIDTH/`ADDR_WIDTH/`DATA_WIDTH macros already used by the DMA master.
- One sub-module, `axi_rsp_arb`: the 1-bit round-robin AW/AR arbiter, including the prio_wr register.
- The SRAM itself is external. For the bench a behavioural model is supplied.

## Test plan
- Write then read back:
  - Stimulus: AW addr 0x100, len 3, size 2, INCR; data 0x11111111..0x44444444, wstrb 4'hF.
  - Response: SRAM words 0x40..0x43 written, bresp OKAY. A matching AR returns the 4 words with rlast on beat 3.
- Byte strobes:
  - Stimulus: write 0xAABBCCDD with wstrb 4'b0101 over an existing word 0x00000000.
  - Response: the word reads back 0x00BB00DD.
- Arbitration:
  - Stimulus: AW and AR valid in the same cycle, twice in a row.
  - Response: the first grant goes to write, the second to read.
- Error:
  - Stimulus: AR with size 1, and AW whose last word address is MEM_WORDS.
  - Response: rresp/bresp = SLVERR on all beats, rdata 0, no SRAM write strobes.
- Backpressure:
  - Stimulus: rready held low 5 cycles during beat 1 of a read burst.
  - Response: rvalid stays 1 and rdata stays stable, with no extra SRAM reads.
- Reset mid-burst:
  - Stimulus: assert rst after write beat 2 of a len-7 burst.
  - Response: outputs take reset values the next cycle, words 3..7 remain unwritten, and a new AW is accepted afterwards.

Source files
------------

// File: rtl/axi_sram_responder_pkg.sv
// Shared definitions for the AXI4 SRAM responder.
// Bus width macros match the ones already used by the DMA master. Localparam
// mirrors of the macros, response and burst codes, the FSM state type and a
// burst legality check are shared by the responder files.

`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 8
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef BURST_WIDTH
`define BURST_WIDTH 2
`endif
`ifndef BRESP_WIDTH
`define BRESP_WIDTH 2
`endif
`ifndef RRESP_WIDTH
`define RRESP_WIDTH 2
`endif

package axi_sram_responder_pkg;

  localparam int unsigned ID_W    = `ID_WIDTH;
  localparam int unsigned ADDR_W  = `ADDR_WIDTH;
  localparam int unsigned DATA_W  = `DATA_WIDTH;
  localparam int unsigned LEN_W   = `LEN_WIDTH;
  localparam int unsigned SIZE_W  = `SIZE_WIDTH;
  localparam int unsigned BURST_W = `BURST_WIDTH;
  localparam int unsigned BRESP_W = `BRESP_WIDTH;
  localparam int unsigned RRESP_W = `RRESP_WIDTH;

  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [SIZE_W-1:0]  SIZE_WORD   = 3'd2;
  localparam logic [1:0]         RESP_OKAY   = 2'b00;
  localparam logic [1:0]         RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA
  } axi_rsp_state_e;

  // A burst is refused when it is not full-word INCR or its last word falls
  // outside the SRAM.
  function automatic logic burst_err(input logic [SIZE_W-1:0]  size,
                                     input logic [BURST_W-1:0] burst,
                                     input logic [31:0]        word,
                                     input logic [LEN_W-1:0]   len,
                                     input int unsigned        mem_words);
    return (size != SIZE_WORD) || (burst != BURST_INCR) ||
           ((word + 32'(len)) >= mem_words);
  endfunction

endpackage

// File: rtl/axi_sram_responder_if.sv
// AXI4 bus between the DMA master and the SRAM responder.
// slave modport: responder side (AW/W/AR payload and valids in, readies and
// B/R responses out). master modport: the mirror image.

interface axi_sram_responder_if;
  import axi_sram_responder_pkg::*;

  logic [ID_W-1:0]      awid_s_i;
  logic [ADDR_W-1:0]    awaddr_s_i;
  logic [LEN_W-1:0]     awlen_s_i;
  logic [SIZE_W-1:0]    awsize_s_i;
  logic [BURST_W-1:0]   awburst_s_i;
  logic                 awvalid_s_i;
  logic                 awready_s_o;

  logic [DATA_W-1:0]    wdata_s_i;
  logic [DATA_W/8-1:0]  wstrb_s_i;
  logic                 wlast_s_i;
  logic                 wvalid_s_i;
  logic                 wready_s_o;

  logic [ID_W-1:0]      bid_s_o;
  logic [BRESP_W-1:0]   bresp_s_o;
  logic                 bvalid_s_o;
  logic                 bready_s_i;

  logic [ID_W-1:0]      arid_s_i;
  logic [ADDR_W-1:0]    araddr_s_i;
  logic [LEN_W-1:0]     arlen_s_i;
  logic [SIZE_W-1:0]    arsize_s_i;
  logic [BURST_W-1:0]   arburst_s_i;
  logic                 arvalid_s_i;
  logic                 arready_s_o;

  logic [ID_W-1:0]      rid_s_o;
  logic [DATA_W-1:0]    rdata_s_o;
  logic                 rlast_s_o;
  logic                 rvalid_s_o;
  logic [RRESP_W-1:0]   rresp_s_o;
  logic                 rready_s_i;

  modport slave (
    input  awid_s_i, awaddr_s_i, awlen_s_i, awsize_s_i, awburst_s_i, awvalid_s_i,
    output awready_s_o,
    input  wdata_s_i, wstrb_s_i, wlast_s_i, wvalid_s_i,
    output wready_s_o,
    output bid_s_o, bresp_s_o, bvalid_s_o,
    input  bready_s_i,
    input  arid_s_i, araddr_s_i, arlen_s_i, arsize_s_i, arburst_s_i, arvalid_s_i,
    output arready_s_o,
    output rid_s_o, rdata_s_o, rlast_s_o, rvalid_s_o, rresp_s_o,
    input  rready_s_i
  );

  modport master (
    output awid_s_i, awaddr_s_i, awlen_s_i, awsize_s_i, awburst_s_i, awvalid_s_i,
    input  awready_s_o,
    output wdata_s_i, wstrb_s_i, wlast_s_i, wvalid_s_i,
    input  wready_s_o,
    input  bid_s_o, bresp_s_o, bvalid_s_o,
    output bready_s_i,
    output arid_s_i, araddr_s_i, arlen_s_i, arsize_s_i, arburst_s_i, arvalid_s_i,
    input  arready_s_o,
    input  rid_s_o, rdata_s_o, rlast_s_o, rvalid_s_o, rresp_s_o,
    output rready_s_i
  );

endinterface

// File: rtl/axi_sram_responder_arb.sv
// axi_rsp_arb: 1-bit round-robin arbiter between AW and AR.
// Ports: clk, rst (sync, active-high), en (responder idle), aw_valid,
// ar_valid in; aw_gnt, ar_gnt out (mutually exclusive).
// prio_wr resets to 1 (write first) and flips after every grant.

module axi_rsp_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic aw_valid,
  input  logic ar_valid,
  output logic aw_gnt,
  output logic ar_gnt
);

  logic prio_wr;

  always_comb begin
    aw_gnt = en & aw_valid & (~ar_valid | prio_wr);
    ar_gnt = en & ar_valid & (~aw_valid | ~prio_wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_wr <= 1'b1;
    end else if (aw_gnt | ar_gnt) begin
      prio_wr <= ~prio_wr;
    end
  end

endmodule

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 slave serving INCR bursts from a word-organised
// single-port SRAM, one transaction at a time, one SRAM access per beat.
// Ports: clk, rst (sync, active-high); axi (AXI4 slave modport);
// mem_cs_o / mem_addr_o / mem_wdata_o / mem_web_o (active-low byte write
// enables) to the SRAM and mem_rdata_i from it (1-cycle read latency).

module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 65536,
  parameter int unsigned AW_MEM    = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_sram_responder_if.slave  axi,
  output logic                 mem_cs_o,
  output logic [AW_MEM-1:0]    mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_web_o,
  input  logic [31:0]          mem_rdata_i
);

  axi_rsp_state_e     state;
  logic [ID_W-1:0]    id_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_q;
  logic [AW_MEM-1:0]  addr_q;
  logic               err_q;
  logic               rd_first;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  rdata_now;
  logic               aw_gnt;
  logic               ar_gnt;
  logic               last_beat;
  logic               mem_we;
  logic               mem_rd;
  logic               unused_addr_bits;

  // Byte offset and bits above the SRAM range take no part in addressing.
  assign unused_addr_bits = ^{axi.awaddr_s_i, axi.araddr_s_i};

  axi_rsp_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       ((state == ST_IDLE) && !rst),
    .aw_valid (axi.awvalid_s_i),
    .ar_valid (axi.arvalid_s_i),
    .aw_gnt   (aw_gnt),
    .ar_gnt   (ar_gnt)
  );

  assign last_beat = (beat_q == len_q);
  assign rdata_now = err_q ? '0 : mem_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      rd_first <= 1'b0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (aw_gnt) begin
            id_q   <= axi.awid_s_i;
            len_q  <= axi.awlen_s_i;
            beat_q <= '0;
            addr_q <= axi.awaddr_s_i[AW_MEM+1:2];
            err_q  <= burst_err(axi.awsize_s_i, axi.awburst_s_i,
                                32'(axi.awaddr_s_i[AW_MEM+1:2]),
                                axi.awlen_s_i, MEM_WORDS);
            state  <= ST_WR_DATA;
          end else if (ar_gnt) begin
            id_q   <= axi.arid_s_i;
            len_q  <= axi.arlen_s_i;
            beat_q <= '0;
            addr_q <= axi.araddr_s_i[AW_MEM+1:2];
            err_q  <= burst_err(axi.arsize_s_i, axi.arburst_s_i,
                                32'(axi.araddr_s_i[AW_MEM+1:2]),
                                axi.arlen_s_i, MEM_WORDS);
            state  <= ST_RD_REQ;
          end
        end
        ST_WR_DATA: begin
          if (axi.wvalid_s_i) begin
            // wlast must coincide with beat len; any disagreement poisons the burst.
            if (axi.wlast_s_i != last_beat) err_q <= 1'b1;
            addr_q <= addr_q + 1'b1;
            beat_q <= beat_q + 1'b1;
            if (last_beat) state <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (axi.bready_s_i) state <= ST_IDLE;
        end
        ST_RD_REQ: begin
          rd_first <= 1'b1;
          state    <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (rd_first) begin
            rd_first <= 1'b0;
            rdata_q  <= rdata_now;
          end
          if (axi.rready_s_i) begin
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              addr_q <= addr_q + 1'b1;
              beat_q <= beat_q + 1'b1;
              state  <= ST_RD_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // SRAM strobes are qualified with rst so a reset cycle never writes.
  always_comb begin
    mem_we      = (state == ST_WR_DATA) && axi.wvalid_s_i && !err_q && !rst;
    mem_rd      = (state == ST_RD_REQ) && !err_q && !rst;
    mem_cs_o    = mem_we | mem_rd;
    mem_addr_o  = addr_q;
    mem_web_o   = mem_we ? ~axi.wstrb_s_i : '1;
    mem_wdata_o = mem_we ? axi.wdata_s_i : '0;
  end

  always_comb begin
    axi.awready_s_o = aw_gnt;
    axi.arready_s_o = ar_gnt;
    axi.wready_s_o  = (state == ST_WR_DATA);
    axi.bvalid_s_o  = (state == ST_WR_RESP);
    axi.bid_s_o     = id_q;
    axi.bresp_s_o   = ((state == ST_WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    axi.rvalid_s_o  = (state == ST_RD_DATA);
    axi.rid_s_o     = id_q;
    axi.rlast_s_o   = (state == ST_RD_DATA) && last_beat;
    axi.rresp_s_o   = ((state == ST_RD_DATA) && err_q) ? RESP_SLVERR : RESP_OKAY;
    // SRAM data only becomes valid in the first RD_DATA cycle, so it is passed
    // straight through then and held from the capture register afterwards.
    axi.rdata_s_o   = ((state == ST_RD_DATA) && rd_first) ? rdata_now : rdata_q;
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
module tb_axi_sram_responder;
  import axi_sram_responder_pkg::*;

  localparam int unsigned MEMW = 256;
  localparam int unsigned AWM  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_responder_if bus ();

  logic            mem_cs;
  logic [AWM-1:0]  mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_web;
  logic [31:0]     mem_rdata = '0;

  axi_sram_responder #(.MEM_WORDS(MEMW), .AW_MEM(AWM)) dut (
    .clk         (clk),
    .rst         (rst),
    .axi         (bus),
    .mem_cs_o    (mem_cs),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_web_o   (mem_web),
    .mem_rdata_i (mem_rdata)
  );

  // Behavioural SRAM with access counters
  logic [31:0] sram    [MEMW];
  logic [31:0] ref_mem [MEMW];
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_web == 4'hF) begin
        mem_rdata <= sram[mem_addr];
        rd_cnt    <= rd_cnt + 1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (!mem_web[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.awready_s_o === 1'b1 && bus.arready_s_o === 1'b1) begin
      errors++;
      $error("FAIL both_ready observed=1 expected=0");
    end
  end

  function automatic bit exp_err_of(input logic [31:0] addr, input int len,
                                    input logic [2:0] size, input logic [1:0] burst);
    int word;
    word = int'(addr / 4);
    return (size != 3'd2) || (burst != 2'b01) || (word + len >= int'(MEMW));
  endfunction

  task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    bus.awaddr_s_i = addr; bus.awlen_s_i = len; bus.awsize_s_i = size;
    bus.awburst_s_i = burst; bus.awid_s_i = id; bus.awvalid_s_i = 1'b1;
  endtask

  task automatic drive_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    bus.araddr_s_i = addr; bus.arlen_s_i = len; bus.arsize_s_i = size;
    bus.arburst_s_i = burst; bus.arid_s_i = id; bus.arvalid_s_i = 1'b1;
  endtask

  task automatic wait_aw_hs();
    int n = 0;
    #1;
    while (bus.awready_s_o !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
    chk("aw_handshake", bus.awready_s_o, 1);
    @(negedge clk);
    bus.awvalid_s_i = 1'b0;
  endtask

  task automatic wait_ar_hs();
    int n = 0;
    #1;
    while (bus.arready_s_o !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
    chk("ar_handshake", bus.arready_s_o, 1);
    @(negedge clk);
    bus.arvalid_s_i = 1'b0;
  endtask

  // dmode: 0 random, 1 dval*(beat+1), 2 constant dval; strb 0 means random non-zero
  task automatic w_beats(input int word, input int len, input bit err,
                         input int dmode, input logic [31:0] dval, input logic [3:0] strb);
    int unsigned wc0;
    wc0 = wr_cnt;
    chk("wready_first", bus.wready_s_o, 1);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] d;
      logic [3:0]  st;
      d  = (dmode == 0) ? $urandom : ((dmode == 1) ? dval * (i + 1) : dval);
      st = (strb != 4'h0) ? strb : 4'($urandom_range(1, 15));
      bus.wdata_s_i = d; bus.wstrb_s_i = st; bus.wlast_s_i = (i == len); bus.wvalid_s_i = 1'b1;
      if (!err)
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[word + i][8*b +: 8] = d[8*b +: 8];
      @(negedge clk);
    end
    bus.wvalid_s_i = 1'b0; bus.wlast_s_i = 1'b0;
    chk("w_sram_writes", wr_cnt - wc0, err ? 0 : len + 1);
  endtask

  task automatic b_check(input logic [3:0] id, input bit err);
    chk("bvalid", bus.bvalid_s_o, 1);
    chk("bid", bus.bid_s_o, id);
    chk("bresp", bus.bresp_s_o, err ? 2 : 0);
    bus.bready_s_i = 1'b1;
    @(negedge clk);
    bus.bready_s_i = 1'b0;
    chk("bvalid_drop", bus.bvalid_s_o, 0);
  endtask

  task automatic r_beats(input logic [3:0] id, input int word, input int len,
                         input bit err, input int stall_beat);
    int unsigned rc0;
    rc0 = rd_cnt;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] exp;
      int unsigned rcs;
      chk("r_req_gap", bus.rvalid_s_o, 0);
      @(negedge clk);
      exp = err ? 32'h0 : ref_mem[word + i];
      chk("rvalid", bus.rvalid_s_o, 1);
      chk("rdata", bus.rdata_s_o, exp);
      chk("rresp", bus.rresp_s_o, err ? 2 : 0);
      chk("rlast", bus.rlast_s_o, (i == len));
      chk("rid", bus.rid_s_o, id);
      if (i == stall_beat) begin
        rcs = rd_cnt;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_rvalid", bus.rvalid_s_o, 1);
          chk("stall_rdata", bus.rdata_s_o, exp);
        end
        chk("stall_no_reads", rd_cnt - rcs, 0);
      end
      bus.rready_s_i = 1'b1;
      @(negedge clk);
      bus.rready_s_i = 1'b0;
    end
    chk("r_sram_reads", rd_cnt - rc0, err ? 0 : len + 1);
  endtask

  task automatic write_txn(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id,
                           input int dmode, input logic [31:0] dval, input logic [3:0] strb);
    bit e;
    e = exp_err_of(addr, len, size, burst);
    drive_aw(addr, 8'(len), size, burst, id);
    wait_aw_hs();
    w_beats(int'(addr / 4), len, e, dmode, dval, strb);
    b_check(id, e);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int stall_beat);
    bit e;
    e = exp_err_of(addr, len, size, burst);
    drive_ar(addr, 8'(len), size, burst, id);
    wait_ar_hs();
    r_beats(id, int'(addr / 4), len, e, stall_beat);
  endtask

  initial begin
    int mism;
    for (int w = 0; w < int'(MEMW); w++) begin sram[w] = '0; ref_mem[w] = '0; end
    bus.awid_s_i = '0; bus.awaddr_s_i = '0; bus.awlen_s_i = '0; bus.awsize_s_i = '0;
    bus.awburst_s_i = '0; bus.awvalid_s_i = 1'b0;
    bus.wdata_s_i = '0; bus.wstrb_s_i = '0; bus.wlast_s_i = 1'b0; bus.wvalid_s_i = 1'b0;
    bus.bready_s_i = 1'b0;
    bus.arid_s_i = '0; bus.araddr_s_i = '0; bus.arlen_s_i = '0; bus.arsize_s_i = '0;
    bus.arburst_s_i = '0; bus.arvalid_s_i = 1'b0; bus.rready_s_i = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", bus.awready_s_o, 0);
    chk("rst_arready", bus.arready_s_o, 0);
    chk("rst_wready", bus.wready_s_o, 0);
    chk("rst_bvalid", bus.bvalid_s_o, 0);
    chk("rst_rvalid", bus.rvalid_s_o, 0);
    chk("rst_bresp", bus.bresp_s_o, 0);
    chk("rst_rresp", bus.rresp_s_o, 0);
    chk("rst_rdata", bus.rdata_s_o, 0);
    chk("rst_rid", bus.rid_s_o, 0);
    chk("rst_bid", bus.bid_s_o, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_web", mem_web, 4'hF);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Arbitration: simultaneous AW/AR twice; write first, then read
    drive_aw(32'h40, 8'd0, 3'd2, 2'b01, 4'h1);
    drive_ar(32'h100, 8'd0, 3'd2, 2'b01, 4'h2);
    #1;
    chk("arb1_awready", bus.awready_s_o, 1);
    chk("arb1_arready", bus.arready_s_o, 0);
    @(negedge clk);
    bus.awvalid_s_i = 1'b0;
    w_beats(32'h10, 0, 1'b0, 0, 32'h0, 4'hF);
    b_check(4'h1, 1'b0);
    drive_aw(32'h44, 8'd0, 3'd2, 2'b01, 4'h3);
    #1;
    chk("arb2_arready", bus.arready_s_o, 1);
    chk("arb2_awready", bus.awready_s_o, 0);
    @(negedge clk);
    bus.arvalid_s_i = 1'b0;
    r_beats(4'h2, 32'h40, 0, 1'b0, -1);
    wait_aw_hs();
    w_beats(32'h11, 0, 1'b0, 0, 32'h0, 4'hF);
    b_check(4'h3, 1'b0);

    // Write then read back
    write_txn(32'h100, 3, 3'd2, 2'b01, 4'h4, 1, 32'h11111111, 4'hF);
    chk("wr_word_40", sram[8'h40], 32'h11111111);
    chk("wr_word_43", sram[8'h43], 32'h44444444);
    read_txn(32'h100, 3, 3'd2, 2'b01, 4'h4, -1);

    // Byte strobes over a zero word
    write_txn(32'h80, 0, 3'd2, 2'b01, 4'h5, 2, 32'h0, 4'hF);
    write_txn(32'h80, 0, 3'd2, 2'b01, 4'h5, 2, 32'hAABBCCDD, 4'b0101);
    chk("strobe_word", sram[8'h20], 32'h00BB00DD);
    read_txn(32'h80, 0, 3'd2, 2'b01, 4'h6, -1);

    // Error bursts
    read_txn(32'h100, 1, 3'd1, 2'b01, 4'h7, -1);
    write_txn(32'd1008, 4, 3'd2, 2'b01, 4'h8, 0, 32'h0, 4'hF);
    write_txn(32'h0C0, 1, 3'd2, 2'b00, 4'h9, 0, 32'h0, 4'hF);
    read_txn(32'd1020, 0, 3'd2, 2'b01, 4'hA, -1);

    // Backpressure on beat 1
    read_txn(32'h100, 3, 3'd2, 2'b01, 4'hB, 1);

    // Reset mid-burst after beat 2 of a len-7 write
    drive_aw(32'h200, 8'd7, 3'd2, 2'b01, 4'hC);
    wait_aw_hs();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] d;
      d = $urandom;
      bus.wdata_s_i = d; bus.wstrb_s_i = 4'hF; bus.wlast_s_i = 1'b0; bus.wvalid_s_i = 1'b1;
      ref_mem[8'h80 + i] = d;
      @(negedge clk);
    end
    bus.wdata_s_i = $urandom; rst = 1'b1;
    #1;
    chk("rst_cycle_no_write", mem_web, 4'hF);
    @(negedge clk);
    rst = 1'b0; bus.wvalid_s_i = 1'b0;
    chk("mid_rst_wready", bus.wready_s_o, 0);
    chk("mid_rst_bvalid", bus.bvalid_s_o, 0);
    chk("mid_rst_mem_cs", mem_cs, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    for (int k = 0; k < 8; k++) chk("mid_rst_word", sram[8'h80 + k], ref_mem[8'h80 + k]);
    write_txn(32'h210, 1, 3'd2, 2'b01, 4'hD, 0, 32'h0, 4'h0);
    read_txn(32'h200, 7, 3'd2, 2'b01, 4'hD, -1);

    // Randomized write/read pairs against the reference memory
    for (int t = 0; t < 12; t++) begin
      int word, len;
      logic [3:0] id;
      word = int'($urandom_range(0, MEMW - 1));
      len  = int'($urandom_range(0, 7));
      id   = 4'($urandom);
      write_txn(32'(word * 4), len, 3'd2, 2'b01, id, 0, 32'h0, 4'h0);
      read_txn(32'(word * 4), len, 3'd2, 2'b01, id, int'($urandom_range(0, 9)));
    end

    mism = 0;
    for (int w = 0; w < int'(MEMW); w++) if (sram[w] !== ref_mem[w]) mism++;
    chk("sram_image", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
